// File: rtl/index_mem_reader.sv
// Read-side sequencer for the indexed memory pair: walks len index entries from base,
// dereferences each into the data memory and streams the words out with their position.
module index_mem_reader #(
  parameter int unsigned AW     = 4,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          oob,
  output logic [AW-1:0] idx_addr,
  input  logic [DW-1:0] idx_rdata,
  output logic [AW-1:0] dat_addr,
  input  logic [DW-1:0] dat_rdata,
  output logic [DW-1:0] dout,
  output logic [AW-1:0] dout_pos,
  output logic          dout_valid,
  input  logic          dout_ready
);

  localparam int unsigned CW      = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, IDX_WAIT, DAT_WAIT, OUT, FIN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic [AW:0]     len_q, len_d;
  logic [AW-1:0]   k_q, k_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic            busy_d, done_d, oob_d, dout_valid_d;
  logic [AW-1:0]   idx_addr_d, dat_addr_d, dout_pos_d;
  logic [DW-1:0]   dout_d;

  logic wait_done_c, hs_c, last_c, ptr_hi_c;

  assign wait_done_c = (wcnt_q == CW'(RD_LAT));
  assign hs_c        = dout_valid && dout_ready;
  assign last_c      = ({1'b0, k_q} == (len_q - LEN_ONE));
  assign ptr_hi_c    = ((idx_rdata >> AW) != '0);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      k_q        <= '0;
      wcnt_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      oob        <= 1'b0;
      idx_addr   <= '0;
      dat_addr   <= '0;
      dout       <= '0;
      dout_pos   <= '0;
      dout_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      k_q        <= k_d;
      wcnt_q     <= wcnt_d;
      busy       <= busy_d;
      done       <= done_d;
      oob        <= oob_d;
      idx_addr   <= idx_addr_d;
      dat_addr   <= dat_addr_d;
      dout       <= dout_d;
      dout_pos   <= dout_pos_d;
      dout_valid <= dout_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = (len == '0) ? FIN : IDX_WAIT;
      IDX_WAIT: if (wait_done_c) state_d = DAT_WAIT;
      DAT_WAIT: if (wait_done_c) state_d = OUT;
      OUT:      if (hs_c) state_d = last_c ? FIN : IDX_WAIT;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next values for datapath and registered outputs
  always_comb begin
    base_d       = base_q;
    len_d        = len_q;
    k_d          = k_q;
    wcnt_d       = wcnt_q;
    busy_d       = busy;
    done_d       = 1'b0;
    oob_d        = oob;
    idx_addr_d   = idx_addr;
    dat_addr_d   = dat_addr;
    dout_d       = dout;
    dout_pos_d   = dout_pos;
    dout_valid_d = dout_valid;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d = base;
          len_d  = (len > LEN_MAX) ? LEN_MAX : len;
          oob_d  = 1'b0;
          busy_d = 1'b1;
          k_d    = '0;
          wcnt_d = '0;
          if (len != '0) idx_addr_d = base;
        end
      end
      IDX_WAIT: begin
        // Out-of-range pointers still proceed using their low bits
        if (wait_done_c) begin
          wcnt_d     = '0;
          dat_addr_d = idx_rdata[AW-1:0];
          oob_d      = oob | ptr_hi_c;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      DAT_WAIT: begin
        if (wait_done_c) begin
          wcnt_d       = '0;
          dout_d       = dat_rdata;
          dout_pos_d   = k_q;
          dout_valid_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      OUT: begin
        if (hs_c) begin
          dout_valid_d = 1'b0;
          if (!last_c) begin
            k_d        = k_q + AW'(1);
            idx_addr_d = base_q + k_q + AW'(1);
          end
        end
      end
      FIN: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_index_mem_reader.sv
// Scoreboard bench for index_mem_reader: random and directed gathers checked against
// a queue of expected words computed directly from the memory contents.
module tb_index_mem_reader;

  logic       clk = 1'b0;
  logic       reset, start, dout_ready;
  logic [3:0] base;
  logic [4:0] len;
  logic       busy, done, oob, dout_valid;
  logic [3:0] idx_addr, dat_addr, dout_pos;
  logic [7:0] idx_rdata, dat_rdata, dout;

  logic [7:0] imem [16];
  logic [7:0] dmem [16];

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] pos;
    logic [3:0] ia;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  index_mem_reader #(.AW(4), .DW(8), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .oob(oob),
    .idx_addr(idx_addr), .idx_rdata(idx_rdata),
    .dat_addr(dat_addr), .dat_rdata(dat_rdata),
    .dout(dout), .dout_pos(dout_pos), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories, one cycle latency
  always @(posedge clk) begin
    idx_rdata <= imem[idx_addr];
    dat_rdata <= dmem[dat_addr];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on every handshake, checks hold while stalled
  initial begin
    bit         stall;
    logic [7:0] sd;
    logic [3:0] sp;
    exp_t       e;
    stall = 1'b0;
    sd = '0;
    sp = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (stall) chk("stall_hold", 32'({dout_valid, dout, dout_pos}), 32'({1'b1, sd, sp}));
        if (dout_valid && dout_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_out", 32'(1), 32'(0));
          end else begin
            e = q.pop_front();
            chk("dout", 32'(dout), 32'(e.d));
            chk("dout_pos", 32'(dout_pos), 32'(e.pos));
            chk("idx_addr", 32'(idx_addr), 32'(e.ia));
          end
          stall = 1'b0;
        end else if (dout_valid) begin
          stall = 1'b1;
          sd = dout;
          sp = dout_pos;
        end else begin
          stall = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
  end

  task automatic recover();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
  endtask

  // mode: 0 ready held high, 1 ready toggles, 2 ready random
  task automatic run_seq(input int b, input int l, input int mode, input bit intrude);
    int   n, cyc, first_v, dc0, ptr;
    bit   busy_ok, exp_oob;
    exp_t e;
    n = (l > 16) ? 16 : l;
    exp_oob = 1'b0;
    for (int k = 0; k < n; k++) begin
      ptr = int'(imem[(b + k) % 16]);
      if (ptr > 15) exp_oob = 1'b1;
      e.d   = dmem[ptr % 16];
      e.pos = 4'(k);
      e.ia  = 4'((b + k) % 16);
      q.push_back(e);
    end
    dc0 = done_cnt;
    base = 4'(b);
    len = 5'(l);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    first_v = -1;
    busy_ok = 1'b1;
    chk("busy_after_start", 32'(busy), 32'(1));
    chk("oob_cleared", 32'(oob), 32'(0));
    while (!done && cyc < 3000) begin
      if (!busy) busy_ok = 1'b0;
      case (mode)
        0: dout_ready = 1'b1;
        1: dout_ready = cyc[0];
        default: dout_ready = 1'($urandom % 2);
      endcase
      if (intrude && cyc == 6) begin
        start = 1'b1;
        base = 4'(b + 5);
        len = 5'd3;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
      if (dout_valid && first_v < 0) first_v = cyc;
    end
    start = 1'b0;
    dout_ready = 1'b0;
    if (!done) begin
      chk("done_timeout", 32'(0), 32'(1));
      recover();
      return;
    end
    chk("busy_until_done", 32'(busy_ok), 32'(1));
    chk("busy_low_at_done", 32'(busy), 32'(0));
    chk("oob_at_done", 32'(oob), 32'(exp_oob));
    chk("all_outputs_seen", 32'(q.size()), 32'(0));
    if (n == 0) begin
      chk("zero_len_done_cycle", 32'(cyc), 32'(1));
      chk("zero_len_no_valid", 32'(first_v), 32'(-1));
    end else begin
      chk("first_valid_latency", 32'(first_v), 32'(4));
      if (mode == 0) chk("done_latency", 32'(cyc), 32'(5 * n + 1));
    end
    tick();
    chk("done_one_cycle", 32'(done), 32'(0));
    chk("done_count", 32'(done_cnt - dc0), 32'(1));
    chk("oob_sticky", 32'(oob), 32'(exp_oob));
  endtask

  task automatic reset_mid_op();
    int dc0;
    dc0 = done_cnt;
    for (int k = 0; k < 16; k++) begin
      q.push_back('{d: dmem[int'(imem[k]) % 16], pos: 4'(k), ia: 4'(k)});
    end
    base = 4'd0;
    len = 5'd16;
    dout_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    reset = 1'b1;
    tick();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_valid", 32'(dout_valid), 32'(0));
    chk("rst_data", 32'({dout, dout_pos, idx_addr, dat_addr, oob}), 32'(0));
    reset = 1'b0;
    q.delete();
    dout_ready = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("rst_no_done", 32'(done_cnt - dc0), 32'(0));
    chk("rst_stays_idle", 32'(busy), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base = '0;
    len = '0;
    dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      imem[i] = 8'(15 - i);
      dmem[i] = 8'(8'h10 + i);
    end
    repeat (3) tick();
    chk("reset_outputs", 32'({busy, done, oob, dout_valid, dout, dout_pos}), 32'(0));
    chk("reset_addrs", 32'({idx_addr, dat_addr}), 32'(0));
    reset = 1'b0;
    tick();

    run_seq(0, 16, 0, 1'b0);
    run_seq(14, 4, 1, 1'b0);
    run_seq(5, 0, 0, 1'b0);
    run_seq(3, 31, 2, 1'b0);

    imem[3] = 8'hA5;
    run_seq(0, 8, 0, 1'b0);
    imem[3] = 8'd12;
    run_seq(0, 2, 0, 1'b0);

    reset_mid_op();
    run_seq(0, 2, 0, 1'b0);

    run_seq(2, 6, 0, 1'b1);

    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 16; i++) begin
        imem[i] = 8'($urandom_range(0, 19));
        dmem[i] = 8'($urandom);
      end
      run_seq(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 2)), 1'($urandom % 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/index_mem_reader.md
Name: index_mem_reader

Overview:
- Read-side sequencer for the indexed memory pair: on `start`, walks `len` consecutive entries of the index memory, beginning at `base`.
- Each index entry is used as a pointer into the data memory. Each fetched data word is emitted on a valid/ready stream, tagged with its position.
- Counterpart of the loader that fills the index and data memories through write-enable/address/data ports.
- Sits between the synchronous-read memory ports and the downstream consumer.

Parameters:
- AW, 4, address width of both memories (depth 2^AW).
- DW, 8, width of index entries and data words; DW >= AW.
- RD_LAT, 1, synchronous read latency of both memories in clock edges (1..3).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high; one clock and reset for the whole block.
- start  input  1  one-cycle request, sampled only in IDLE.
- base  input  AW  first index-memory address, sampled with start.
- len  input  AW+1  entry count; 0 = none; values above 2^AW clamp to 2^AW.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse at end of sequence.
- oob  output  1  sticky: some pointer had nonzero bits above AW; cleared by accepted start or reset.
- idx_addr  output  AW  registered index-memory read address.
- idx_rdata  input  DW  index-memory read data.
- dat_addr  output  AW  registered data-memory read address.
- dat_rdata  input  DW  data-memory read data.
- dout  output  DW  fetched data word.
- dout_pos  output  AW  element number k (0..len-1) of dout.
- dout_valid  output  1  dout/dout_pos valid.
- dout_ready  input  1  consumer accepts when valid and ready are high on the same edge.

Behaviour:
- Reset, and any edge with reset high including mid-sequence:
  - State goes to IDLE.
  - busy, done, oob, dout_valid = 0; dout, dout_pos, idx_addr, dat_addr = 0.
  - Internal counters = 0; no done pulse is produced.
- States: IDLE, IDX_WAIT, DAT_WAIT, OUT, FIN.
- IDLE, start=1 at edge E0:
  - Latch base and clamped len; clear oob; busy <= 1.
  - If len = 0: go to FIN.
  - Otherwise: idx_addr <= base, k <= 0, go to IDX_WAIT.
- IDX_WAIT:
  - Wait counter spans RD_LAT+1 edges after idx_addr update; idx_rdata is sampled on edge RD_LAT+1.
  - At that edge: dat_addr <= idx_rdata[AW-1:0]; oob <= oob | (idx_rdata[DW-1:AW] != 0); go to DAT_WAIT.
  - An out-of-range pointer still proceeds, using its low bits.
- DAT_WAIT:
  - Same RD_LAT+1 edge wait; dat_rdata is sampled.
  - At that edge: dout <= dat_rdata, dout_pos <= k, dout_valid <= 1; go to OUT.
- OUT:
  - dout and dout_pos are held stable while dout_valid && !dout_ready.
  - On handshake: dout_valid <= 0.
    - If k = len-1: go to FIN.
    - Else: k <= k+1, idx_addr <= base+k+1 (mod 2^AW, wraps), go to IDX_WAIT.
- FIN: done <= 1 for exactly one cycle, busy <= 0, return to IDLE.
- Latency:
  - With RD_LAT=1, dout_valid rises after edge E0+4.
  - With dout_ready held high, each element occupies 5 cycles (2+2 read waits + 1 handshake).
  - done is high on the cycle after the last handshake.
- Boundaries:
  - start while busy is ignored; base/len changes while busy have no effect.
  - start and reset together: reset wins.
  - base+len beyond 2^AW wraps the index address to 0.
  - len = 2^AW reads every index entry once.
  - The last element's done pulse precedes any new start; a start is accepted no earlier than the cycle after done.
  - Only idx_addr and dat_addr change memory-side; no write ports.

Test Plan:
- Indexed gather:
  - Stimulus: index mem[i] = 15-i, data mem[j] = 8'h10+j; start with base=0, len=16; dout_ready=1.
  - Required: 16 outputs, dout = 8'h1F down to 8'h10, dout_pos 0..15; busy high throughout; one done pulse; oob=0; first dout_valid after E0+4.
- Wrap and backpressure:
  - Stimulus: base=14, len=4, dout_ready toggled 0/1 every cycle.
  - Required: idx_addr sequence 14,15,0,1; dout stable while stalled; exactly 4 handshakes; done once.
- Zero length and clamp:
  - Stimulus: len=0.
  - Required: no dout_valid; busy=1 for one cycle, then done pulse.
  - Stimulus: len=5'd31.
  - Required: treated as 16 outputs.
- Out-of-range pointer:
  - Stimulus: index mem[3] = 8'hA5.
  - Required: element 3 reads data mem[5]; oob=1 stays set after done; next start clears it.
- Reset mid-operation:
  - Stimulus: assert reset for 1 cycle during DAT_WAIT of element 2.
  - Required: all outputs 0 next cycle, no done pulse.
  - Stimulus: a fresh start with base=0, len=2.
  - Required: normal behaviour from element 0.
- Start while busy:
  - Stimulus: second start pulse with a different base during element 1.
  - Required: ignored; original sequence completes unchanged.
